// File: rtl/demux4_buf_pkg.sv
// Shared constants and helpers for the demux4_buf block: lane count,
// lane index width, lane-selection mode encodings.
package demux4_buf_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    logic [NUM_LANES-1:0] oh;
    oh       = '0;
    oh[lane] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux4_buf_if.sv
// Stream-in / four-lanes-out bus of demux4_buf. The master drives the input
// word and lane consumers' ready; the slave is the demultiplexer itself.
interface demux4_buf_if #(
  parameter int DATA_W = 1
);
  logic                flush;
  logic                mode;
  logic [1:0]          sel;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_ready;
  logic [3:0]          out_valid;
  logic [4*DATA_W-1:0] out_data;
  logic [3:0]          out_ready;
  logic [1:0]          rr_lane;
  logic                frame_done;

  modport master (
    output flush, mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, rr_lane, frame_done
  );

  modport slave (
    input  flush, mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, rr_lane, frame_done
  );
endinterface

// File: rtl/demux4_buf_lane_buf.sv
// One-entry valid/ready holding register for a single output lane.
// Flush clears valid only; data is kept so an idle lane never toggles.
module demux4_buf_lane_buf #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // Load has priority over drain so a lane drained and refilled in one cycle stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer: steers the input stream onto one of four
// buffered lanes, chosen by sel or by an internal round-robin pointer.
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  demux4_buf_if.slave  bus
);

  logic [LANE_W-1:0]           tgt_s;
  logic                        rdy_s;
  logic                        acc_s;
  logic [NUM_LANES-1:0]        load_s;
  logic [NUM_LANES-1:0]        valid_s;
  logic [NUM_LANES*DATA_W-1:0] data_s;
  logic [LANE_W-1:0]           rr_q, rr_d;
  logic                        fd_q, fd_d;

  // Target decode, ready mux and next state of the pointer / frame flag.
  always_comb begin
    tgt_s  = (bus.mode == MODE_RR) ? rr_q : bus.sel;
    // Ready looks only at the target lane, so a stalled lane never blocks the others.
    rdy_s  = rst_n && !bus.flush && (!valid_s[tgt_s] || bus.out_ready[tgt_s]);
    acc_s  = bus.in_valid && rdy_s;
    load_s = acc_s ? lane_onehot(tgt_s) : '0;
    if (bus.flush) begin
      rr_d = '0;
    end else if (acc_s && (bus.mode == MODE_RR)) begin
      rr_d = rr_q + 2'd1;
    end else begin
      rr_d = rr_q;
    end
    fd_d = !bus.flush && acc_s && (bus.mode == MODE_RR) && (rr_q == 2'd3);
  end

  // Round-robin pointer and frame-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      fd_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      fd_q <= fd_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux4_buf_lane_buf #(.DATA_W(DATA_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (bus.flush),
      .load_i  (load_s[k]),
      .ready_i (bus.out_ready[k]),
      .data_i  (bus.in_data),
      .valid_o (valid_s[k]),
      .data_o  (data_s[k*DATA_W +: DATA_W])
    );
  end

  assign bus.in_ready   = rdy_s;
  assign bus.out_valid  = valid_s;
  assign bus.out_data   = data_s;
  assign bus.rr_lane    = rr_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_demux4_buf.sv
// Self-checking bench for demux4_buf: directed vector table, hand-written
// round-robin/async-reset sequence, then random traffic against a lane model.
module tb_demux4_buf;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  demux4_buf_if #(.DATA_W(8)) bus ();

  demux4_buf #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       mode;
    logic [1:0] sel;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] out_ready;
    logic       exp_ready;
    logic [3:0] exp_valid;
    logic [1:0] exp_rr;
    logic       exp_fd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  // model state for the random phase: per-lane occupancy and last word
  bit         mv[4];
  logic [7:0] md[4];
  int         mrr;
  bit         mfd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic f, input logic m, input logic [1:0] s, input logic v,
                     input logic [7:0] d, input logic [3:0] ordy, input logic er,
                     input logic [3:0] ev, input logic [1:0] err, input logic efd,
                     input logic [31:0] ed);
    vec_t x;
    x.flush = f; x.mode = m; x.sel = s; x.in_valid = v; x.in_data = d;
    x.out_ready = ordy; x.exp_ready = er; x.exp_valid = ev; x.exp_rr = err;
    x.exp_fd = efd; x.exp_data = ed;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic f, input logic m, input logic [1:0] s, input logic v,
                       input logic [7:0] d, input logic [3:0] ordy);
    bus.flush = f; bus.mode = m; bus.sel = s; bus.in_valid = v;
    bus.in_data = d; bus.out_ready = ordy;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0);

    //   flush mode sel v data  ordy    rdy valid    rr    fd   lanes {3,2,1,0}
    add(1'b0, 1'b0, 2'd2, 1'b1, 8'hA5, 4'hF, 1'b1, 4'b0100, 2'd0, 1'b0, 32'h00A5_0000);
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h3C, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b0, 32'h00A5_003C);
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h11, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b0, 32'h00A5_0011);
    add(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 32'h00A5_0011);
    add(1'b0, 1'b1, 2'd0, 1'b1, 8'h10, 4'hF, 1'b1, 4'b0001, 2'd1, 1'b0, 32'h00A5_0010);
    add(1'b0, 1'b1, 2'd0, 1'b1, 8'h11, 4'hF, 1'b1, 4'b0010, 2'd2, 1'b0, 32'h00A5_1110);
    add(1'b0, 1'b1, 2'd0, 1'b1, 8'h12, 4'hF, 1'b1, 4'b0100, 2'd3, 1'b0, 32'h0012_1110);
    add(1'b0, 1'b1, 2'd0, 1'b1, 8'h13, 4'hF, 1'b1, 4'b1000, 2'd0, 1'b1, 32'h1312_1110);
    add(1'b0, 1'b1, 2'd0, 1'b1, 8'h14, 4'hF, 1'b1, 4'b0001, 2'd1, 1'b0, 32'h1312_1114);
    add(1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 2'd1, 1'b0, 32'h1312_1114);
    add(1'b0, 1'b0, 2'd1, 1'b1, 8'h55, 4'hD, 1'b1, 4'b0010, 2'd1, 1'b0, 32'h1312_5514);
    add(1'b0, 1'b0, 2'd1, 1'b1, 8'h66, 4'hD, 1'b0, 4'b0010, 2'd1, 1'b0, 32'h1312_5514);
    add(1'b0, 1'b0, 2'd3, 1'b1, 8'h77, 4'hD, 1'b1, 4'b1010, 2'd1, 1'b0, 32'h7712_5514);
    add(1'b0, 1'b0, 2'd3, 1'b0, 8'h00, 4'hD, 1'b1, 4'b0010, 2'd1, 1'b0, 32'h7712_5514);
    add(1'b0, 1'b0, 2'd3, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0000, 2'd1, 1'b0, 32'h7712_5514);
    add(1'b0, 1'b0, 2'd2, 1'b1, 8'h21, 4'hB, 1'b1, 4'b0100, 2'd1, 1'b0, 32'h7721_5514);
    add(1'b0, 1'b1, 2'd0, 1'b1, 8'h31, 4'hB, 1'b1, 4'b0110, 2'd2, 1'b0, 32'h7721_3114);
    add(1'b0, 1'b1, 2'd0, 1'b1, 8'h32, 4'hB, 1'b0, 4'b0100, 2'd2, 1'b0, 32'h7721_3114);
    add(1'b0, 1'b1, 2'd0, 1'b1, 8'h32, 4'hB, 1'b0, 4'b0100, 2'd2, 1'b0, 32'h7721_3114);
    add(1'b0, 1'b1, 2'd0, 1'b1, 8'h32, 4'hF, 1'b1, 4'b0100, 2'd3, 1'b0, 32'h7732_3114);
    add(1'b0, 1'b0, 2'd0, 1'b1, 8'h40, 4'h0, 1'b1, 4'b0101, 2'd3, 1'b0, 32'h7732_3140);
    add(1'b0, 1'b0, 2'd1, 1'b1, 8'h41, 4'h0, 1'b1, 4'b0111, 2'd3, 1'b0, 32'h7732_4140);
    add(1'b1, 1'b1, 2'd0, 1'b1, 8'h99, 4'h0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'h7732_4140);
    add(1'b0, 1'b1, 2'd0, 1'b1, 8'h50, 4'hF, 1'b1, 4'b0001, 2'd1, 1'b0, 32'h7732_4150);

    #3;
    chk("reset out_valid", {28'd0, bus.out_valid}, 32'd0);
    chk("reset out_data", bus.out_data, 32'd0);
    chk("reset rr_lane", {30'd0, bus.rr_lane}, 32'd0);
    chk("reset frame_done", {31'd0, bus.frame_done}, 32'd0);
    drive(1'b0, 1'b0, 2'd0, 1'b1, 8'hEE, 4'hF);
    #1;
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].flush, vecs[i].mode, vecs[i].sel, vecs[i].in_valid,
            vecs[i].in_data, vecs[i].out_ready);
      #1;
      chk($sformatf("row%0d in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].exp_ready});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", i), {28'd0, bus.out_valid}, {28'd0, vecs[i].exp_valid});
      chk($sformatf("row%0d rr_lane", i), {30'd0, bus.rr_lane}, {30'd0, vecs[i].exp_rr});
      chk($sformatf("row%0d frame_done", i), {31'd0, bus.frame_done}, {31'd0, vecs[i].exp_fd});
      chk($sformatf("row%0d out_data", i), bus.out_data, vecs[i].exp_data);
    end

    // finish a frame from rr_lane=1 with all consumers stalled, then reset mid-cycle
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b1, 2'd0, 1'b1, 8'h51 + 8'(j), 4'h0);
      @(posedge clk);
      #1;
    end
    chk("frame out_valid", {28'd0, bus.out_valid}, 32'h0000_000F);
    chk("frame frame_done", {31'd0, bus.frame_done}, 32'd1);
    chk("frame out_data", bus.out_data, 32'h5352_5150);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", {28'd0, bus.out_valid}, 32'd0);
    chk("async rr_lane", {30'd0, bus.rr_lane}, 32'd0);
    chk("async frame_done", {31'd0, bus.frame_done}, 32'd0);
    chk("async in_ready", {31'd0, bus.in_ready}, 32'd0);
    #2;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0;
      md[k] = 8'h00;
    end
    mrr = 0;
    mfd = 1'b0;
    @(posedge clk);
    #1;

    for (int c = 0; c < 400; c++) begin
      logic       f, m, v, rdy, acc;
      logic [1:0] s;
      logic [7:0] d;
      logic [3:0] ordy;
      int         t;
      f    = ($urandom_range(0, 15) == 0);
      m    = 1'($urandom_range(0, 1));
      s    = 2'($urandom_range(0, 3));
      v    = ($urandom_range(0, 3) != 0);
      d    = 8'($urandom);
      ordy = 4'($urandom_range(0, 15));
      drive(f, m, s, v, d, ordy);
      t    = m ? mrr : int'(s);
      rdy  = !f && (!mv[t] || ordy[t]);
      acc  = v && rdy;
      #1;
      chk($sformatf("rand%0d in_ready", c), {31'd0, bus.in_ready}, {31'd0, rdy});
      @(posedge clk);
      if (f) begin
        for (int k = 0; k < 4; k++) mv[k] = 1'b0;
        mrr = 0;
        mfd = 1'b0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (acc && t == k) begin
            mv[k] = 1'b1;
            md[k] = d;
          end else if (mv[k] && ordy[k]) begin
            mv[k] = 1'b0;
          end
        end
        mfd = acc && m && (mrr == 3);
        if (acc && m) mrr = (mrr + 1) % 4;
      end
      #1;
      chk($sformatf("rand%0d out_valid", c), {28'd0, bus.out_valid},
          {28'd0, mv[3], mv[2], mv[1], mv[0]});
      chk($sformatf("rand%0d rr_lane", c), {30'd0, bus.rr_lane}, 32'(mrr));
      chk($sformatf("rand%0d frame_done", c), {31'd0, bus.frame_done}, {31'd0, mfd});
      chk($sformatf("rand%0d out_data", c), bus.out_data, {md[3], md[2], md[1], md[0]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
